// File: rtl/wb_regfile_buf.sv
// Write-back consumer: in-order write buffer retiring into a 32x32 register file, two combinational read ports.
// Optional feature macro: REGFILE_BYPASS_EN (forward reads from pending buffer entries; rd_stall tied 0).
module wb_regfile_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     wb_hold,
  input  logic [ADDR_W-1:0]        raddr1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic [DATA_W-1:0]        rdata1,
  output logic [DATA_W-1:0]        rdata2,
  output logic                     rd_stall,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] buf_addr [DEPTH];
  logic [DATA_W-1:0] buf_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [DATA_W-1:0] regs [NREG];

  logic accept, push, pop;

  assign wb_ready = (buf_count != CNT_W'(DEPTH));
  assign accept   = wb_valid && wb_ready;
  // Writes to r0 complete the handshake but never occupy a buffer slot.
  assign push     = accept && (wb_addr != '0);
  assign pop      = (buf_count != '0) && !wb_hold;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   buf_count <= buf_count + CNT_W'(1);
        2'b01:   buf_count <= buf_count - CNT_W'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  // NOTE: buffer payload is not reset; only entries inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= wb_addr;
      buf_data[tail] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (pop && (buf_addr[head] != '0)) begin
      regs[buf_addr[head]] <= buf_data[head];
    end
  end

  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic [PTR_W-1:0]  idx;
`ifndef REGFILE_BYPASS_EN
  logic [1:0]        hit;
`endif

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;

  // Entries are scanned oldest to youngest so the youngest match wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    idx = head;
`ifndef REGFILE_BYPASS_EN
    hit = '0;
`endif
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs[raddr[p]];
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if ((CNT_W'(k) < buf_count) && (buf_addr[idx] == raddr[p]) && (raddr[p] != '0)) begin
`ifdef REGFILE_BYPASS_EN
          rdata[p] = buf_data[idx];
`else
          hit[p] = 1'b1;
`endif
        end
      end
      if (raddr[p] == '0) rdata[p] = '0;
    end
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

`ifdef REGFILE_BYPASS_EN
  assign rd_stall = 1'b0;
`else
  assign rd_stall = |hit;
`endif

endmodule

// File: tb/tb_wb_regfile_buf.sv
// Self-checking bench for wb_regfile_buf: directed scenarios plus randomized traffic against a
// queue-based reference model. Follows REGFILE_BYPASS_EN if it is defined for the build.
module tb_wb_regfile_buf;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, wb_hold;
  logic        wb_ready;
  logic [4:0]  wb_addr, raddr1, raddr2;
  logic [31:0] wb_data, rdata1, rdata2;
  logic        rd_stall;
  logic [1:0]  buf_count;

  int n_checks = 0;
  int n_pass   = 0;

  wb_regfile_buf #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_hold(wb_hold), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .rd_stall(rd_stall), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes as a FIFO queue, architectural state as a plain array.
  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] mregs [32];

  function automatic void model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == a) return mq[i].data;
`endif
    return mregs[a];
  endfunction

  function automatic logic exp_stall(input logic [4:0] a1, input logic [4:0] a2);
`ifdef REGFILE_BYPASS_EN
    return 1'b0;
`else
    foreach (mq[i])
      if ((a1 != 0 && mq[i].addr == a1) || (a2 != 0 && mq[i].addr == a2)) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_count();
    return 2'(mq.size());
  endfunction

  function automatic logic exp_ready();
    return mq.size() < DEPTH;
  endfunction

  // One clock edge: advance DUT and model together, then settle 1ns past the edge.
  task automatic cycle();
    bit   acc;
    ent_t e;
    acc = wb_valid && (mq.size() < DEPTH);
    e.addr = wb_addr;
    e.data = wb_data;
    @(posedge clk);
    if (mq.size() > 0 && !wb_hold) begin
      ent_t h;
      h = mq.pop_front();
      if (h.addr != 0) mregs[h.addr] = h.data;
    end
    if (acc && e.addr != 0) mq.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wb_valid = 0; wb_hold = 0; wb_addr = 0; wb_data = 0;
    raddr1 = 5'd5; raddr2 = 5'd31;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++; if (rdata1 !== 32'h0) $display("FAIL reset_rd1 got %h want 0", rdata1); else n_pass++;
    n_checks++; if (rdata2 !== 32'h0) $display("FAIL reset_rd2 got %h want 0", rdata2); else n_pass++;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", wb_ready); else n_pass++;
    n_checks++; if (buf_count !== 2'd0) $display("FAIL reset_count got %0d want 0", buf_count); else n_pass++;
    n_checks++; if (rd_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", rd_stall); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    wb_valid = 1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF; raddr1 = 5'd3; raddr2 = 5'd0;
    cycle();
    wb_valid = 0;
    n_checks++; if (buf_count !== 2'd1) $display("FAIL wr_count got %0d want 1", buf_count); else n_pass++;
    n_checks++; if (rdata1 !== exp_rd(3)) $display("FAIL wr_rd_early got %h want %h", rdata1, exp_rd(3)); else n_pass++;
    n_checks++; if (rd_stall !== exp_stall(raddr1, raddr2)) $display("FAIL wr_stall_early got %b want %b", rd_stall, exp_stall(raddr1, raddr2)); else n_pass++;
    cycle();
    n_checks++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL wr_rd_late got %h want deadbeef", rdata1); else n_pass++;
    n_checks++; if (rd_stall !== 1'b0) $display("FAIL wr_stall_late got %b want 0", rd_stall); else n_pass++;
  endtask

  task automatic test_hold();
    wb_hold = 1; raddr1 = 5'd1; raddr2 = 5'd0;
    wb_valid = 1; wb_addr = 5'd1; wb_data = 32'd1;
    cycle();
    wb_data = 32'd2;
    cycle();
    wb_valid = 0;
    n_checks++; if (buf_count !== 2'd2) $display("FAIL hold_count got %0d want 2", buf_count); else n_pass++;
    n_checks++; if (wb_ready !== 1'b0) $display("FAIL hold_ready got %b want 0", wb_ready); else n_pass++;
    n_checks++; if (rdata1 !== exp_rd(1)) $display("FAIL hold_rd1 got %h want %h", rdata1, exp_rd(1)); else n_pass++;
    n_checks++; if (rd_stall !== exp_stall(raddr1, raddr2)) $display("FAIL hold_stall got %b want %b", rd_stall, exp_stall(raddr1, raddr2)); else n_pass++;
    wb_hold = 0;
    cycle();
    n_checks++; if (buf_count !== 2'd1) $display("FAIL release_count1 got %0d want 1", buf_count); else n_pass++;
    cycle();
    n_checks++; if (buf_count !== 2'd0) $display("FAIL release_count0 got %0d want 0", buf_count); else n_pass++;
    n_checks++; if (rdata1 !== 32'd2) $display("FAIL release_rd1 got %h want 2", rdata1); else n_pass++;
  endtask

  task automatic test_r0();
    wb_valid = 1; wb_addr = 5'd0; wb_data = 32'h1234; raddr1 = 5'd0; raddr2 = 5'd0;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL r0_ready got %b want 1", wb_ready); else n_pass++;
    cycle();
    wb_valid = 0;
    n_checks++; if (buf_count !== 2'd0) $display("FAIL r0_count got %0d want 0", buf_count); else n_pass++;
    cycle();
    n_checks++; if (rdata1 !== 32'h0) $display("FAIL r0_rd got %h want 0", rdata1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    wb_hold = 1;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_addr = 5'(10 + i); wb_data = $urandom;
      if (i == 2) begin
        n_checks++; if (wb_ready !== 1'b0) $display("FAIL b2b_third_ready got %b want 0", wb_ready); else n_pass++;
      end
      cycle();
    end
    n_checks++; if (buf_count !== 2'd2) $display("FAIL b2b_full_count got %0d want 2", buf_count); else n_pass++;
    wb_hold = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wb_valid = 0;
      cycle();
      n_checks++; if (buf_count !== exp_count()) $display("FAIL b2b_drain_count got %0d want %0d", buf_count, exp_count()); else n_pass++;
    end
    // Continuous traffic to wrap the pointers several times.
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1; wb_addr = 5'($urandom_range(1, 31)); wb_data = $urandom;
      cycle();
      n_checks++; if (buf_count !== exp_count()) $display("FAIL wrap_count got %0d want %0d", buf_count, exp_count()); else n_pass++;
    end
    wb_valid = 0;
    cycle(); cycle(); cycle();
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      #1;
      n_checks++; if (rdata1 !== exp_rd(raddr1)) $display("FAIL wrap_rd r%0d got %h want %h", a, rdata1, exp_rd(raddr1)); else n_pass++;
    end
  endtask

  task automatic test_reset_midcycle();
    wb_hold = 1; raddr1 = 5'd3; raddr2 = 5'd7;
    wb_valid = 1; wb_addr = 5'd7; wb_data = 32'hA5A5A5A5;
    cycle();
    wb_addr = 5'd9; wb_data = 32'h5A5A5A5A;
    cycle();
    wb_valid = 0;
    n_checks++; if (buf_count !== 2'd2) $display("FAIL mid_pre_count got %0d want 2", buf_count); else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (buf_count !== 2'd0) $display("FAIL mid_count got %0d want 0", buf_count); else n_pass++;
    n_checks++; if (wb_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", wb_ready); else n_pass++;
    n_checks++; if (rdata1 !== 32'h0) $display("FAIL mid_rd1 got %h want 0", rdata1); else n_pass++;
    n_checks++; if (rdata2 !== 32'h0) $display("FAIL mid_rd2 got %h want 0", rdata2); else n_pass++;
    n_checks++; if (rd_stall !== 1'b0) $display("FAIL mid_stall got %b want 0", rd_stall); else n_pass++;
    #1 rst_n = 1'b1; wb_hold = 0;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_hold  = ($urandom_range(0, 3) == 0);
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      cycle();
      n_checks++; if (buf_count !== exp_count()) $display("FAIL rnd_count @%0d got %0d want %0d", i, buf_count, exp_count()); else n_pass++;
      n_checks++; if (wb_ready !== exp_ready()) $display("FAIL rnd_ready @%0d got %b want %b", i, wb_ready, exp_ready()); else n_pass++;
      n_checks++; if (rdata1 !== exp_rd(raddr1)) $display("FAIL rnd_rd1 @%0d r%0d got %h want %h", i, raddr1, rdata1, exp_rd(raddr1)); else n_pass++;
      n_checks++; if (rdata2 !== exp_rd(raddr2)) $display("FAIL rnd_rd2 @%0d r%0d got %h want %h", i, raddr2, rdata2, exp_rd(raddr2)); else n_pass++;
      n_checks++; if (rd_stall !== exp_stall(raddr1, raddr2)) $display("FAIL rnd_stall @%0d got %b want %b", i, rd_stall, exp_stall(raddr1, raddr2)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_r0();
    test_back_to_back();
    test_reset_midcycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
